// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds funct3 encodings, the FSM state type and the default wait-state count.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int DEF_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and a sized load/store access.
// Ports: we/funct3/addr[1:0]/wdata describe the access, rword is the addressed
// memory word; be/wword drive the store, rdata is the extended load result and
// err flags a bad access. Error detection exists only with DMEM_ERR_EN defined;
// otherwise addresses are force-aligned and illegal funct3 acts as a word access.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    logic        is_b;
    logic        is_h;
    logic        sext;
    logic [1:0]  lane;
    logic [31:0] shifted;

    // Anything not decoded as byte or halfword is a word access.
    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        sext = 1'b0;
        unique case (funct3)
            F3_B:    begin is_b = 1'b1; sext = 1'b1; end
            F3_H:    begin is_h = 1'b1; sext = 1'b1; end
            F3_BU:   is_b = !we;
            F3_HU:   is_h = !we;
            default: ;
        endcase
    end

`ifdef DMEM_ERR_EN
    logic illegal;
    logic misal;

    assign illegal = (funct3 == 3'd3) || (funct3[2:1] == 2'b11)
                     || (we && funct3[2]);
    assign misal   = is_h ? addr[0] : (!is_b && addr != 2'b00);
    assign err     = illegal || misal;
    assign lane    = addr;
`else
    assign err  = 1'b0;
    assign lane = is_b ? addr : (is_h ? {addr[1], 1'b0} : 2'b00);
`endif

    always_comb begin
        be = 4'b0000;
        if (we && !err) begin
            if (is_b)
                be = 4'b0001 << lane;
            else if (is_h)
                be = lane[1] ? 4'b1100 : 4'b0011;
            else
                be = 4'b1111;
        end
    end

    assign wword = is_b ? {4{wdata[7:0]}}
                 : is_h ? {2{wdata[15:0]}}
                 : wdata;

    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        rdata = 32'd0;
        if (!we && !err) begin
            if (is_b)
                rdata = {{24{sext & shifted[7]}}, shifted[7:0]};
            else if (is_h)
                rdata = {{16{sext & shifted[15]}}, shifted[15:0]};
            else
                rdata = rword;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a
// response held until rsp_ready (RSP_HOLD=1) or pulsed for one cycle (RSP_HOLD=0).
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_we/req_addr/
// req_wdata/req_funct3 request side; rsp_valid/rsp_ready/rsp_rdata/rsp_err
// response side. Optional DMEM_ERR_EN enables misaligned/illegal-funct3 errors.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int RSP_HOLD    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_funct3;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [2:0]        cur_funct3;

    logic        commit;
    logic [3:0]  be;
    logic [31:0] wword;
    logic [31:0] rword;
    logic [31:0] al_rdata;
    logic        al_err;

    logic [31:0] mem [WORDS];

    // With no wait states the access commits on the accept edge, before the
    // request is latched, so the lane logic looks at the live request in IDLE.
    assign cur_we     = (state == IDLE) ? req_we     : lat_we;
    assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;

    assign rword = mem[cur_addr[ADDR_W-1:2]];

    dmem_lane_align u_align (
        .we     (cur_we),
        .funct3 (cur_funct3),
        .addr   (cur_addr[1:0]),
        .wdata  (cur_wdata),
        .rword  (rword),
        .be     (be),
        .wword  (wword),
        .rdata  (al_rdata),
        .err    (al_err)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (RSP_HOLD == 0 || rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                lat_we     <= req_we;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
                cnt        <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (commit) begin
                rsp_rdata <= al_rdata;
                rsp_err   <= al_err;
            end
        end
    end

    // Memory is never reset; reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[cur_addr[ADDR_W-1:2]][i*8 +: 8] <= wword[i*8 +: 8];
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target serving the core's load/store port over a valid/ready request/response handshake.
- Memory is a byte-addressed, word-organised array. It supports byte, halfword and word accesses selected by the instruction funct3, with sign or zero extension on loads.
- Configurable wait states let the core's multi-cycle memory path be exercised. The core-side load/store logic is the initiator; this block is the responder.

Parameters:
- ADDR_W, 12, byte-address width; memory size is 2**ADDR_W bytes.
- WAIT_CYCLES, 1, extra cycles between request accept and response; 0 is legal.
- RSP_HOLD, 1, when 1 the response is held until rsp_ready; when 0 rsp_ready is ignored and rsp_valid pulses for one cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- req_funct3  input  3  access size and sign: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data, extended; 0 for stores and errors.
- rsp_err  output  1  access error (misaligned or illegal funct3).

Behaviour:
- Reset
  - Synchronous, active-high; clk and rst are the only clock and reset.
  - Reset puts the FSM in IDLE and clears all outputs: req_ready=0 during reset, 1 from the first cycle after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The wait counter is cleared. Memory contents are not cleared.
- FSM states
  - IDLE: req_ready=1. Accept when req_valid&&req_ready and latch we, addr, wdata and funct3. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: req_ready=0. The counter counts WAIT_CYCLES cycles, then the FSM goes to RESP.
  - RESP: rsp_valid=1 and req_ready=0. Leave for IDLE on rsp_ready (RSP_HOLD=1) or after one cycle (RSP_HOLD=0). No new request is accepted in the same cycle the response completes.
- Latency
  - Accept edge to rsp_valid is WAIT_CYCLES+1 cycles.
  - Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles minimum.
- Memory access
  - The access commits on the edge entering RESP. Stores write on that edge; load data is registered on the same edge.
- Stores
  - Byte enables come from addr[1:0] and size: SB sets 1 lane, SH sets lanes {1:0} or {3:2}, SW sets all 4.
  - Data is replicated into the selected lanes. Unselected bytes are untouched.
- Loads
  - The addressed lane is extracted. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Errors
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: 3, 6 or 7; store funct3>2 is also illegal.
  - On error: rsp_err=1, rsp_rdata=0, no memory write.
- Simultaneous events
  - req_valid is ignored while not in IDLE; the initiator must hold the request until accepted.
- Reset mid-operation
  - Drops the transaction with no response.
  - A store is suppressed if rst is asserted on the edge that would commit it, because reset has priority.
- Outputs while not in RESP
  - rsp_rdata and rsp_err keep their last value; only rsp_valid qualifies them.

Optional Feature:
- DMEM_ERR_EN defined: misalignment and illegal-funct3 detection as above.
- DMEM_ERR_EN undefined:
  - rsp_err is tied to 0.
  - Address bits below the access size are ignored (force-aligned).
  - Illegal funct3 is treated as word access, zero-extended.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum {IDLE, WAIT, RESP}.
  - Default WAIT_CYCLES.
- Sub-module dmem_lane_align: combinational store byte-enable and lane replication, load lane extract and extension, and misalignment flag.

Test Plan:
- SW 0xDEADBEEF at 0x010, then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly WAIT_CYCLES+1 cycles after accept.
- After the first test, SB 0x5A at 0x012, then LW 0x010 -> 0xDE5ABEEF; LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE.
- SH 0x8001 at 0x016, then LH 0x016 -> 0xFFFF8001; LHU 0x016 -> 0x00008001.
- With DMEM_ERR_EN: LW 0x011 -> rsp_err=1, rsp_rdata=0. SH at 0x015 -> rsp_err=1, and a following LW 0x014 shows the word unchanged.
- RSP_HOLD=1, rsp_ready held low 5 cycles -> rsp_valid held steady with stable data and req_ready=0 throughout. A second req_valid is not accepted until the cycle after the rsp_ready handshake.
- Store issued and rst asserted in WAIT -> no response, req_ready=1 the cycle after reset releases, and a later LW of that address returns the old value.
